// File: rtl/hamwt_pkg.sv
// hamwt_pkg: shared types and helpers for the streaming Hamming-weight engine.
//   state_t    - control FSM states
//   cnt_width  - width of the weight counter (holds 0..max_words*data_w)
//   loc_width  - width of a set-bit location (0..max_words*data_w-1)
//   popcount   - number of set bits in a word of up to POP_MAX bits
package hamwt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widest word popcount can take; narrower words are zero-extended by the caller.
    localparam int POP_MAX = 256;

    function automatic int cnt_width(input int max_words, input int data_w);
        return $clog2(max_words * data_w + 1);
    endfunction

    function automatic int loc_width(input int max_words, input int data_w);
        return $clog2(max_words * data_w);
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/hamwt_lsb_enc.sv
// hamwt_lsb_enc: lowest-set-bit encoder.
//   word    in  DATA_W          word to examine
//   idx     out $clog2(DATA_W)  index of the lowest set bit (0 when word is zero)
//   none    out 1               word has no set bit
//   cleared out DATA_W          word with its lowest set bit cleared
module hamwt_lsb_enc #(
    parameter int DATA_W = 8,
    localparam int IDX_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] word,
    output logic [IDX_W-1:0]  idx,
    output logic              none,
    output logic [DATA_W-1:0] cleared
);

    // Scanning from the top down lets the lowest set bit win the last assignment.
    always_comb begin
        // NOTE: give every always_comb output a default before any branch so no latch is inferred.
        idx = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (word[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign none    = (word == '0);
    // Subtracting one borrows through the trailing zeros and clears the lowest set bit.
    assign cleared = word & (word - DATA_W'(1));

endmodule

// File: rtl/hamwt_stream.sv
// hamwt_stream: streaming Hamming-weight engine.
// Counts set bits across a packet of DATA_W-bit words, emits the location of
// every set bit one per handshake, then presents the total weight and an
// overflow flag (packet longer than MAX_WORDS) on a result handshake.
//   clk, clear                  clock, synchronous active-high reset
//   pkt_starts                  packet-start strobe (restarts an open packet)
//   in_valid/in_ready           word handshake for bin_data, in_last
//   loc_valid/loc_ready         location handshake for loc_data
//   res_valid/res_ready         result handshake for ham_wt, ovf
//   pkt_abort                   one-cycle pulse when an open packet is discarded
module hamwt_stream
    import hamwt_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_WORDS = 4,
    localparam int CNT_W    = cnt_width(MAX_WORDS, DATA_W),
    localparam int LOC_W    = loc_width(MAX_WORDS, DATA_W)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              pkt_starts,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] bin_data,
    input  logic              in_last,
    output logic              loc_valid,
    input  logic              loc_ready,
    output logic [LOC_W-1:0]  loc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  ham_wt,
    output logic              ovf,
    output logic              pkt_abort
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam int BIT_W = $clog2(DATA_W);

    state_t              state, state_n;
    logic [CNT_W-1:0]    count, count_n;
    logic [IDX_W-1:0]    word_idx, word_idx_n;
    logic [DATA_W-1:0]   hold, hold_n;
    logic [LOC_W-1:0]    base, base_n;
    logic                last, last_n;
    logic                ovf_r, ovf_n;
    logic                abort_r, abort_n;

    logic [BIT_W-1:0]    enc_idx;
    logic                enc_none;
    logic [DATA_W-1:0]   enc_cleared;
    logic                counted;

    hamwt_lsb_enc #(.DATA_W(DATA_W)) u_lsb_enc (
        .word    (hold),
        .idx     (enc_idx),
        .none    (enc_none),
        .cleared (enc_cleared)
    );

    // Word index saturates at MAX_WORDS, so anything below it is still countable.
    assign counted = (word_idx < IDX_W'(MAX_WORDS));

    always_comb begin
        state_n    = state;
        count_n    = count;
        word_idx_n = word_idx;
        hold_n     = hold;
        base_n     = base;
        last_n     = last;
        ovf_n      = ovf_r;
        abort_n    = 1'b0;

        case (state)
            IDLE: begin
                if (pkt_starts) begin
                    state_n    = ACCUM;
                    count_n    = '0;
                    word_idx_n = '0;
                    hold_n     = '0;
                    ovf_n      = 1'b0;
                end
            end
            ACCUM, SCAN: begin
                if (pkt_starts) begin
                    // Restart wins over any handshake in the same cycle.
                    state_n    = ACCUM;
                    count_n    = '0;
                    word_idx_n = '0;
                    hold_n     = '0;
                    ovf_n      = 1'b0;
                    abort_n    = 1'b1;
                end else if (state == ACCUM) begin
                    if (in_valid) begin
                        if (counted) begin
                            count_n    = count + CNT_W'(popcount(POP_MAX'(bin_data)));
                            word_idx_n = word_idx + IDX_W'(1);
                        end else begin
                            ovf_n = 1'b1;
                        end
                        if (counted && bin_data != '0) begin
                            hold_n  = bin_data;
                            base_n  = LOC_W'(word_idx) * LOC_W'(DATA_W);
                            last_n  = in_last;
                            state_n = SCAN;
                        end else if (in_last) begin
                            state_n = DONE;
                        end
                    end
                end else if (loc_ready) begin
                    hold_n = enc_cleared;
                    if (enc_cleared == '0) begin
                        state_n = last ? DONE : ACCUM;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clear) begin
            state    <= IDLE;
            count    <= '0;
            word_idx <= '0;
            hold     <= '0;
            base     <= '0;
            last     <= 1'b0;
            ovf_r    <= 1'b0;
            abort_r  <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            word_idx <= word_idx_n;
            hold     <= hold_n;
            base     <= base_n;
            last     <= last_n;
            ovf_r    <= ovf_n;
            abort_r  <= abort_n;
        end
    end

    assign in_ready  = (state == ACCUM);
    assign loc_valid = (state == SCAN) && !enc_none;
    assign loc_data  = loc_valid ? base + LOC_W'(enc_idx) : '0;
    assign res_valid = (state == DONE);
    assign ham_wt    = count;
    assign ovf       = ovf_r;
    assign pkt_abort = abort_r;

endmodule

// File: tb/tb_hamwt_stream.sv
// tb_hamwt_stream: directed self-checking bench for hamwt_stream (DATA_W=8, MAX_WORDS=4).
module tb_hamwt_stream;

    logic       clk = 1'b0;
    logic       clear, pkt_starts, in_valid, in_last, loc_ready, res_ready;
    logic [7:0] bin_data;
    logic       in_ready, loc_valid, res_valid, ovf, pkt_abort;
    logic [4:0] loc_data;
    logic [5:0] ham_wt;

    int checks = 0;
    int errors = 0;
    int got[$];
    bit saw_in_ready;

    hamwt_stream #(.DATA_W(8), .MAX_WORDS(4)) dut (
        .clk        (clk),
        .clear      (clear),
        .pkt_starts (pkt_starts),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin_data   (bin_data),
        .in_last    (in_last),
        .loc_valid  (loc_valid),
        .loc_ready  (loc_ready),
        .loc_data   (loc_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .ham_wt     (ham_wt),
        .ovf        (ovf),
        .pkt_abort  (pkt_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt();
        pkt_starts = 1'b1;
        step();
        pkt_starts = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b expected 1 (word %h)", in_ready, d);
        end
        in_valid = 1'b1;
        bin_data = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        bin_data = '0;
    endtask

    // Records handshaken locations until n are seen or the cycle budget runs out.
    task automatic collect(input int n, input int budget);
        got.delete();
        saw_in_ready = 1'b0;
        for (int c = 0; c < budget && got.size() < n; c++) begin
            if (in_ready) saw_in_ready = 1'b1;
            if (loc_valid && loc_ready) got.push_back(int'(loc_data));
            step();
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL res_release: res_valid=%b expected 0", res_valid);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        checks++;
        if ({in_ready, loc_valid, res_valid, ovf, pkt_abort, ham_wt, loc_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b lv=%b rv=%b ovf=%b abort=%b wt=%0d loc=%0d expected all 0",
                     in_ready, loc_valid, res_valid, ovf, pkt_abort, ham_wt, loc_data);
        end
    endtask

    task automatic test_all_ones();
        start_pkt();
        send_word(8'hFF, 1'b1);
        collect(8, 8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== i) begin
                errors++;
                $display("FAIL ff_loc[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : -1, i);
            end
        end
        checks++;
        if (res_valid !== 1'b1 || ham_wt !== 6'd8 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ff_result: rv=%b wt=%0d ovf=%b expected 1/8/0", res_valid, ham_wt, ovf);
        end
        release_result();
    endtask

    task automatic test_multi_word();
        int exp_locs[4] = '{3, 5, 7, 16};
        int seen[$];
        start_pkt();
        send_word(8'hA8, 1'b0);
        collect(3, 10);
        seen = got;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mw_ready_after_scan: in_ready=%b expected 1", in_ready);
        end
        send_word(8'h00, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || loc_valid !== 1'b0) begin
            errors++;
            $display("FAIL mw_zero_word: in_ready=%b loc_valid=%b expected 1/0", in_ready, loc_valid);
        end
        send_word(8'h01, 1'b1);
        collect(1, 10);
        seen = {seen, got};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= seen.size() || seen[i] !== exp_locs[i]) begin
                errors++;
                $display("FAIL mw_loc[%0d]: got %0d expected %0d", i, (i < seen.size()) ? seen[i] : -1, exp_locs[i]);
            end
        end
        checks++;
        if (res_valid !== 1'b1 || ham_wt !== 6'd4 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mw_result: rv=%b wt=%0d ovf=%b expected 1/4/0", res_valid, ham_wt, ovf);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        logic rdy_pat[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   exp_loc[5]  = '{3, 5, 5, 5, 7};
        start_pkt();
        send_word(8'hA8, 1'b1);
        for (int c = 0; c < 5; c++) begin
            loc_ready = rdy_pat[c];
            checks++;
            if (loc_valid !== 1'b1 || int'(loc_data) !== exp_loc[c] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_cycle[%0d]: lv=%b loc=%0d rdy=%b expected 1/%0d/0",
                         c, loc_valid, loc_data, in_ready, exp_loc[c]);
            end
            step();
        end
        loc_ready = 1'b1;
        checks++;
        if (res_valid !== 1'b1 || ham_wt !== 6'd3) begin
            errors++;
            $display("FAIL bp_result: rv=%b wt=%0d expected 1/3", res_valid, ham_wt);
        end
        release_result();
    endtask

    task automatic test_overflow();
        int seen[$];
        start_pkt();
        for (int w = 0; w < 4; w++) begin
            send_word(8'h01, 1'b0);
            collect(1, 10);
            seen = {seen, got};
        end
        send_word(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= seen.size() || seen[i] !== 8 * i) begin
                errors++;
                $display("FAIL ovf_loc[%0d]: got %0d expected %0d", i, (i < seen.size()) ? seen[i] : -1, 8 * i);
            end
        end
        for (int c = 0; c < 3; c++) begin
            // A start strobe while the result is pending must be ignored.
            pkt_starts = (c == 1);
            checks++;
            if (res_valid !== 1'b1 || ham_wt !== 6'd4 || ovf !== 1'b1 || loc_valid !== 1'b0) begin
                errors++;
                $display("FAIL ovf_hold[%0d]: rv=%b wt=%0d ovf=%b lv=%b expected 1/4/1/0",
                         c, res_valid, ham_wt, ovf, loc_valid);
            end
            step();
        end
        pkt_starts = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || ham_wt !== 6'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after_start: rv=%b wt=%0d ovf=%b expected 1/4/1", res_valid, ham_wt, ovf);
        end
        release_result();
    endtask

    task automatic test_abort();
        start_pkt();
        send_word(8'hF0, 1'b0);
        checks++;
        if (loc_valid !== 1'b1 || loc_data !== 5'd4) begin
            errors++;
            $display("FAIL ab_scan: lv=%b loc=%0d expected 1/4", loc_valid, loc_data);
        end
        pkt_starts = 1'b1;
        step();
        pkt_starts = 1'b0;
        checks++;
        if (pkt_abort !== 1'b1 || in_ready !== 1'b1 || loc_valid !== 1'b0 || ham_wt !== 6'd0) begin
            errors++;
            $display("FAIL ab_pulse: abort=%b rdy=%b lv=%b wt=%0d expected 1/1/0/0",
                     pkt_abort, in_ready, loc_valid, ham_wt);
        end
        step();
        checks++;
        if (pkt_abort !== 1'b0) begin
            errors++;
            $display("FAIL ab_one_cycle: abort=%b expected 0", pkt_abort);
        end
        send_word(8'h03, 1'b1);
        collect(2, 10);
        checks++;
        if (got.size() != 2 || got[0] !== 0 || got[1] !== 1) begin
            errors++;
            $display("FAIL ab_locs: got %0d locations (%0d,%0d) expected 2 (0,1)", got.size(),
                     (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1);
        end
        checks++;
        if (res_valid !== 1'b1 || ham_wt !== 6'd2 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ab_result: rv=%b wt=%0d ovf=%b expected 1/2/0", res_valid, ham_wt, ovf);
        end
        release_result();
    endtask

    task automatic test_clear_mid_packet();
        start_pkt();
        send_word(8'h0F, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({in_ready, loc_valid, res_valid, ovf, pkt_abort, ham_wt, loc_data} !== '0) begin
            errors++;
            $display("FAIL clr_outputs: rdy=%b lv=%b rv=%b ovf=%b abort=%b wt=%0d loc=%0d expected all 0",
                     in_ready, loc_valid, res_valid, ovf, pkt_abort, ham_wt, loc_data);
        end
        in_valid = 1'b1;
        bin_data = 8'h01;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || loc_valid !== 1'b0 || res_valid !== 1'b0 || ham_wt !== 6'd0) begin
                errors++;
                $display("FAIL clr_no_accept[%0d]: rdy=%b lv=%b rv=%b wt=%0d expected 0/0/0/0",
                         c, in_ready, loc_valid, res_valid, ham_wt);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        bin_data = '0;
    endtask

    initial begin
        clear      = 1'b1;
        pkt_starts = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        bin_data   = '0;
        loc_ready  = 1'b1;
        res_ready  = 1'b0;

        test_reset();
        test_all_ones();
        test_multi_word();
        test_backpressure();
        test_overflow();
        test_abort();
        test_clear_mid_packet();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamwt_stream.md
# hamwt_stream

Streaming Hamming-weight engine for the packet datapath, the parametrised successor to the fixed 8-bit `hamwt_sub`. It accepts a packet as a sequence of `DATA_W`-bit words under a valid/ready handshake. It emits the bit index of every set bit, one per cycle, on a location stream instead of a wide fixed location vector. At packet end it presents the total weight and an overflow flag on a result handshake. It sits between the byte deserialiser and the packet checker.

## Interface
- `DATA_W`, 8: word width in bits (≥2).
- `MAX_WORDS`, 4: words per packet that are counted; further words are dropped.
- `CNT_W`, derived: `$clog2(MAX_WORDS*DATA_W+1)`.
- `LOC_W`, derived: `$clog2(MAX_WORDS*DATA_W)`.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `pkt_starts`  in  1  single-cycle packet-start strobe.
- `in_valid`  in  1  `bin_data`/`in_last` valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `bin_data`  in  DATA_W  packet word; bit 0 = lowest location.
- `in_last`  in  1  marks the final word of the packet.
- `loc_valid`  out  1  `loc_data` valid.
- `loc_ready`  in  1  sink accepts the location.
- `loc_data`  out  LOC_W  set-bit location = word_index*DATA_W + bit_index.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  sink accepts the result.
- `ham_wt`  out  CNT_W  total set bits in counted words.
- `ovf`  out  1  packet had more than MAX_WORDS words.
- `pkt_abort`  out  1  one-cycle pulse: unfinished packet discarded by restart.

## Operation
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE: `pkt_starts` → ACCUM; clears count, word index, `ovf`.
- ACCUM: `in_ready`=1. On accept (`in_valid & in_ready`):
  - If index < MAX_WORDS: count += popcount(`bin_data`).
  - If that word is nonzero: latch it into the hold register with base = index*DATA_W and its last flag, then go to SCAN.
  - Otherwise (zero word or dropped word): if `in_last` → DONE, else stay.
  - Index increments, saturating at MAX_WORDS. An accept at index ≥ MAX_WORDS sets `ovf`; the word is neither counted nor scanned.
- SCAN: `in_ready`=0, `loc_valid`=1, `loc_data` = base + index of the lowest set bit in the hold register.
  - On `loc_ready`, clear that bit.
  - When the final bit clears: → DONE if the held word was last, else → ACCUM.
- DONE: `res_valid`=1; `ham_wt`/`ovf` stable; `pkt_starts` ignored. On `res_ready` → IDLE.
- `pkt_starts` in ACCUM or SCAN: discard the packet (count, index, hold, `ovf` cleared), pulse `pkt_abort`, → ACCUM. This takes priority over a same-cycle accept or location handshake.
- `in_valid` outside ACCUM: ignored, no side effects.
- Words arriving before `pkt_starts`: never accepted.
- Arithmetic: unsigned. `ham_wt` cannot wrap because CNT_W covers MAX_WORDS*DATA_W.

## Timing
- Reset: state IDLE. `in_ready`, `loc_valid`, `res_valid`, `ovf`, `pkt_abort` = 0; `ham_wt`, `loc_data` = 0.
- `clear` has priority over all inputs in every state.
- `clear` mid-packet drops everything, with no `pkt_abort` pulse.
- `in_ready` rises the cycle after `pkt_starts`.
- A word with k set bits holds the input for k cycles when `loc_ready` is held high. The next word is accepted on the cycle after the last location handshake.
- Zero last word: `res_valid` rises the cycle after the accept.
- Nonzero last word: `res_valid` rises the cycle after its final location handshake.
- `loc_data` and `loc_valid` must stay stable while `loc_valid & !loc_ready`.
- `res_valid`, `ham_wt` and `ovf` must stay stable until `res_ready`.
- Next `pkt_starts` is honoured the cycle after the result handshake.
- Locations are emitted strictly ascending within a packet.

## Structure
- Package `hamwt_pkg` holds:
  - the state enum;
  - the width helper functions for CNT_W/LOC_W;
  - the popcount function.
- Sub-module `hamwt_lsb_enc` (parametrised DATA_W): takes a word; returns the lowest-set-bit index, a `none` flag, and the word with that bit cleared.
- All state and outputs are registered in the top; `loc_data` is decoded from the hold register.

## Test plan
- DATA_W=8, MAX_WORDS=4, `loc_ready`=1; `pkt_starts`, then 0xFF with `in_last` → locations 0..7 on 8 consecutive cycles; `ham_wt`=8, `ovf`=0.
- Words 0xA8, 0x00, 0x01(last) → locations 3, 5, 7, 16; `ham_wt`=4; the zero word takes one accept cycle.
- 0xA8(last) with `loc_ready` toggling 1,0,0,1,1 → locations 3, 5, 7 each held stable until the handshake; `in_ready` stays 0 throughout.
- Five words of 0x01, last on the fifth → locations 0, 8, 16, 24; `ham_wt`=4, `ovf`=1; `res_valid` held for 3 cycles with `res_ready`=0, values constant.
- `pkt_starts` during SCAN of 0xF0 → `pkt_abort` for 1 cycle. Then 0x03(last) → locations 0, 1, `ham_wt`=2.
- `clear` during SCAN → the next cycle shows all outputs 0 in IDLE; 0x01 without `pkt_starts` is not accepted.
